// File: rtl/fp_match_extract_if.sv
// Bus bundle for fp_match_extract: filter-result beats in, match tokens out.
// The slave modport is the extractor's view; master is the driver/consumer side.
interface fp_match_extract_if #(
   parameter int FP_DWIDTH = 128,
   parameter int POS_WIDTH = 16
);
   logic [FP_DWIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_last;
   logic [POS_WIDTH-1:0] out_pos;
   logic [2:0]           out_bucket;
   logic                 out_eop;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  out_pos, out_bucket, out_eop, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output out_pos, out_bucket, out_eop, out_valid
   );
endinterface

// File: rtl/fp_match_extract.sv
// Serialises cleared filter bits into (byte pos, bucket) tokens plus one eop per packet.
// First token <=3 cycles after an input beat; input has no backpressure, so overflow beats are dropped and counted.
module fp_beat_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             full,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_wr, do_rd;

   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign empty  = (cnt_q == '0);
   assign rd_dat = mem_q[rd_ptr_q];

   always_comb begin
      do_wr    = wr_vld && !full;
      do_rd    = rd_rdy && !empty;
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
   end
endmodule

module fp_match_extract #(
   parameter int FP_DWIDTH  = 128,
   parameter int FIFO_DEPTH = 16,
   parameter int POS_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_match_extract_if.slave    bus,
   output logic [31:0]          drop_cnt
);
   localparam int BPB   = FP_DWIDTH / 64 * 8;
   localparam int IDX_W = $clog2(FP_DWIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_EOP  = 2'd2;

   typedef struct packed {
      logic                 last;
      logic [POS_WIDTH-1:0] base;
      logic [FP_DWIDTH-1:0] bits;
   } beat_t;

   beat_t                fifo_wr_dat, fifo_rd_dat;
   logic                 fifo_full, fifo_empty, pop;

   logic [POS_WIDTH-1:0] offset_q, offset_d;
   logic [31:0]          drop_cnt_q, drop_cnt_d;
   logic [1:0]           state_q, state_d;
   logic [FP_DWIDTH-1:0] work_q, work_d;
   logic [POS_WIDTH-1:0] base_q, base_d;
   logic                 last_q, last_d;
   logic [POS_WIDTH-1:0] out_pos_q, out_pos_d;
   logic [2:0]           out_bucket_q, out_bucket_d;
   logic                 out_eop_q, out_eop_d;
   logic                 out_valid_q, out_valid_d;
   logic [IDX_W-1:0]     low_idx;
   logic                 load;

   // Stored bits are inverted so a set bit means "match still to emit".
   assign fifo_wr_dat = '{last: bus.in_last, base: offset_q, bits: ~bus.in_data};

   fp_beat_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (bus.in_valid),
      .wr_dat (fifo_wr_dat),
      .full   (fifo_full),
      .rd_rdy (pop),
      .rd_dat (fifo_rd_dat),
      .empty  (fifo_empty)
   );

   always_comb begin
      offset_d   = offset_q;
      drop_cnt_d = drop_cnt_q;
      if (bus.in_valid) begin
         offset_d = bus.in_last ? '0 : offset_q + POS_WIDTH'(BPB);
         if (fifo_full && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_comb begin
      low_idx = '0;
      for (int i = FP_DWIDTH - 1; i >= 0; i--) begin
         if (work_q[i]) low_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      work_d       = work_q;
      base_d       = base_q;
      last_d       = last_q;
      out_pos_d    = out_pos_q;
      out_bucket_d = out_bucket_q;
      out_eop_d    = out_eop_q;
      out_valid_d  = out_valid_q;
      pop          = 1'b0;
      // The output register may take a new token when empty or being drained.
      load         = !out_valid_q || bus.out_ready;
      if (load) out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (work_q != '0) begin
               if (load) begin
                  out_valid_d  = 1'b1;
                  out_pos_d    = base_q + POS_WIDTH'(low_idx >> 3);
                  out_bucket_d = low_idx[2:0];
                  out_eop_d    = 1'b0;
                  work_d       = work_q & ~(FP_DWIDTH'(1) << low_idx);
               end
            end else if (last_q) begin
               state_d = ST_EOP;
            end else if (!fifo_empty) begin
               pop = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EOP: begin
            if (load) begin
               out_valid_d  = 1'b1;
               out_pos_d    = base_q + POS_WIDTH'(BPB);
               out_bucket_d = 3'd0;
               out_eop_d    = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_SCAN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         work_d = fifo_rd_dat.bits;
         base_d = fifo_rd_dat.base;
         last_d = fifo_rd_dat.last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset_q     <= '0;
         drop_cnt_q   <= '0;
         state_q      <= ST_IDLE;
         work_q       <= '0;
         base_q       <= '0;
         last_q       <= 1'b0;
         out_pos_q    <= '0;
         out_bucket_q <= '0;
         out_eop_q    <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         offset_q     <= offset_d;
         drop_cnt_q   <= drop_cnt_d;
         state_q      <= state_d;
         work_q       <= work_d;
         base_q       <= base_d;
         last_q       <= last_d;
         out_pos_q    <= out_pos_d;
         out_bucket_q <= out_bucket_d;
         out_eop_q    <= out_eop_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign bus.out_pos    = out_pos_q;
   assign bus.out_bucket = out_bucket_q;
   assign bus.out_eop    = out_eop_q;
   assign bus.out_valid  = out_valid_q;
   assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_fp_match_extract.sv
// Scoreboard bench for fp_match_extract: a byte-count model queues expected tokens, a monitor checks them.
module tb_fp_match_extract;
   typedef struct {
      int pos;
      int bucket;
      bit eop;
   } tok_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] drop_cnt;
   tok_t        exp_q[$];
   tok_t        mon_tok;
   int          checks = 0;
   int          errors = 0;
   int          offset = 0;
   bit          rnd_en = 0;
   bit          stalled = 0;
   logic [20:0] stall_snap;

   always #5 clk = ~clk;

   fp_match_extract_if #(.FP_DWIDTH(128), .POS_WIDTH(16)) bus ();

   fp_match_extract #(.FP_DWIDTH(128), .FIFO_DEPTH(16), .POS_WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .drop_cnt (drop_cnt)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected tokens: one per zero bit in ascending order, then eop if last.
   task automatic model_beat(input logic [127:0] d, input bit last, input bit dropped);
      if (!dropped) begin
         for (int i = 0; i < 128; i++)
            if (!d[i]) exp_q.push_back('{(offset + i / 8) % 65536, i % 8, 1'b0});
         if (last) exp_q.push_back('{(offset + 16) % 65536, 0, 1'b1});
      end
      offset = last ? 0 : (offset + 16) % 65536;
   endtask

   task automatic send(input logic [127:0] d, input bit last, input bit dropped);
      model_beat(d, last, dropped);
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stalled = 0;
      end else begin
         if (stalled)
            check("stall_hold", {bus.out_valid, bus.out_pos, bus.out_bucket, bus.out_eop}, stall_snap);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_token actual pos=%0d bucket=%0d eop=%0d required none @%0t",
                        bus.out_pos, bus.out_bucket, bus.out_eop, $time);
            end else begin
               mon_tok = exp_q.pop_front();
               check("tok_pos", bus.out_pos, mon_tok.pos);
               check("tok_bucket", bus.out_bucket, mon_tok.bucket);
               check("tok_eop", bus.out_eop, mon_tok.eop);
            end
         end
         stalled    = bus.out_valid && !bus.out_ready;
         stall_snap = {bus.out_valid, bus.out_pos, bus.out_bucket, bus.out_eop};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      logic [127:0] d;
      int lat, run, g, plen;

      rst          = 1'b1;
      bus.in_data  = '1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", bus.out_valid, 0);
      check("rst_pos", bus.out_pos, 0);
      check("rst_bucket", bus.out_bucket, 0);
      check("rst_eop", bus.out_eop, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      tick();

      // Two matches in one beat, plus latency from beat to first token.
      bus.out_ready = 1'b1;
      d = '1;
      d[5] = 1'b0;
      d[100] = 1'b0;
      send(d, 1'b1, 1'b0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 10);
      check("first_token_latency_le3", (lat <= 3) ? 1 : 0, 1);
      wait_drain("drain_t1");

      // No-match packet yields only eop; next packet restarts at 0.
      d = '1;
      send(d, 1'b0, 1'b0);
      send(d, 1'b0, 1'b0);
      send(d, 1'b1, 1'b0);
      d[0] = 1'b0;
      send(d, 1'b1, 1'b0);
      wait_drain("drain_t2");

      // All-match beat streams 128 tokens back to back.
      send('0, 1'b1, 1'b0);
      g = 0;
      while (!bus.out_valid && g < 10) begin
         @(negedge clk);
         g++;
      end
      run = 0;
      repeat (128) begin
         if (bus.out_valid) run++;
         @(negedge clk);
      end
      check("burst_consecutive", run, 128);
      tick();
      wait_drain("drain_t3");

      // Random out_ready against the model.
      rnd_en = 1;
      repeat (60) begin
         plen = $urandom_range(1, 4);
         for (int b = 0; b < plen; b++) begin
            g = 0;
            while (exp_q.size() > 8 && g < 2000) begin
               tick();
               g++;
            end
            d = '1;
            repeat ($urandom_range(1, 4)) d[$urandom_range(0, 127)] = 1'b0;
            send(d, b == plen - 1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      rnd_en = 0;
      bus.out_ready = 1'b1;
      wait_drain("drain_t4");
      check("drop_cnt_random", drop_cnt, 0);

      // Overflow: scanner stalled holding one packet, 20-beat burst drops 4.
      bus.out_ready = 1'b0;
      tick();
      d = '1;
      d[$urandom_range(0, 127)] = 1'b0;
      send(d, 1'b1, 1'b0);
      repeat (4) tick();
      for (int b = 0; b < 20; b++) begin
         d = '1;
         d[$urandom_range(0, 127)] = 1'b0;
         send(d, b == 19, b >= 16);
      end
      @(negedge clk);
      check("drop_cnt_overflow", drop_cnt, 4);
      tick();
      bus.out_ready = 1'b1;
      wait_drain("drain_t5a");
      d = '1;
      d[3] = 1'b0;
      send(d, 1'b1, 1'b0);
      wait_drain("drain_t5b");

      // Reset mid-packet with tokens pending.
      bus.out_ready = 1'b0;
      d = '1;
      d[20] = 1'b0;
      d[77] = 1'b0;
      send(d, 1'b0, 1'b0);
      send(d, 1'b0, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      offset = 0;
      @(negedge clk);
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_drop_cnt", drop_cnt, 0);
      tick();
      bus.out_ready = 1'b1;
      repeat (6) tick();
      check("post_rst_no_tokens", exp_q.size(), 0);
      d = '1;
      d[9] = 1'b0;
      send(d, 1'b1, 1'b0);
      wait_drain("drain_t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
